// File: rtl/mmu_sequencer.sv
// Tile sequencer for the systolic matrix unit: walks a job tile by tile,
// handshaking with the weight loader and output writer under a watchdog.
module mmu_sequencer #(
  parameter int unsigned width_height   = 16,
  parameter int unsigned timeout_cycles = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] num_tiles,
  input  logic [7:0] w_base_init,
  input  logic [7:0] in_base_init,
  input  logic       weight_done,
  input  logic       wr_done,
  output logic       wl_start,
  output logic       rd_active,
  output logic [7:0] w_base,
  output logic [7:0] in_base,
  output logic [7:0] tile_idx,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned WD_W = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(timeout_cycles - 1);
  localparam logic [7:0] STRIDE = 8'(width_height);

  typedef enum logic [2:0] {IDLE, LOAD_W, WAIT_W, COMPUTE, WAIT_C} state_e;

  state_e          state_q, state_d;
  logic [7:0]      tiles_q, tiles_d;
  logic [7:0]      tile_q, tile_d;
  logic [7:0]      wb_q, wb_d;
  logic [7:0]      ib_q, ib_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic            wl_q, wl_d;
  logic            rd_q, rd_d;
  logic            done_q, done_d;

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    tiles_d = tiles_q;
    tile_d  = tile_q;
    wb_d    = wb_q;
    ib_d    = ib_q;
    wd_d    = wd_q;
    busy_d  = busy_q;
    err_d   = err_q;
    wl_d    = 1'b0;
    rd_d    = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          tiles_d = num_tiles;
          if (num_tiles != 8'd0) begin
            state_d = LOAD_W;
            busy_d  = 1'b1;
            wl_d    = 1'b1;
            tile_d  = 8'd0;
            wb_d    = w_base_init;
            ib_d    = in_base_init;
          end else begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end
        end
      end
      LOAD_W: begin
        state_d = WAIT_W;
        wd_d    = '0;
      end
      WAIT_W: begin
        // A done input on the final watchdog cycle takes priority over timeout
        if (weight_done) begin
          state_d = COMPUTE;
          rd_d    = 1'b1;
        end else if (wd_q == WD_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      COMPUTE: begin
        state_d = WAIT_C;
        wd_d    = '0;
      end
      WAIT_C: begin
        if (wr_done) begin
          if (tile_q == tiles_q - 8'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = LOAD_W;
            wl_d    = 1'b1;
            tile_d  = tile_q + 8'd1;
            wb_d    = wb_q + STRIDE;
            ib_d    = ib_q + STRIDE;
          end
        end else if (wd_q == WD_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tiles_q <= 8'd0;
      tile_q  <= 8'd0;
      wb_q    <= 8'd0;
      ib_q    <= 8'd0;
      wd_q    <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      wl_q    <= 1'b0;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tiles_q <= tiles_d;
      tile_q  <= tile_d;
      wb_q    <= wb_d;
      ib_q    <= ib_d;
      wd_q    <= wd_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      wl_q    <= wl_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
    end
  end

  assign wl_start  = wl_q;
  assign rd_active = rd_q;
  assign w_base    = wb_q;
  assign in_base   = ib_q;
  assign tile_idx  = tile_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = err_q;

endmodule

// File: tb/tb_mmu_sequencer.sv
// Self-checking bench for mmu_sequencer: tile-job model with random latencies,
// stray handshakes, watchdog timeout/race and reset scenarios.
module tb_mmu_sequencer;

  localparam int unsigned W  = 16;
  localparam int unsigned TO = 255;

  logic       clk = 1'b0;
  logic       reset, start, weight_done, wr_done;
  logic [7:0] num_tiles, w_base_init, in_base_init;
  logic       wl_start, rd_active, busy, done, error;
  logic [7:0] w_base, in_base, tile_idx;

  int checks = 0;
  int fails  = 0;
  int wl_cnt, rd_cnt, done_cnt, busy_cnt, consec;
  logic p_wl = 1'b0, p_rd = 1'b0, p_done = 1'b0;

  mmu_sequencer #(.width_height(W), .timeout_cycles(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .num_tiles(num_tiles),
    .w_base_init(w_base_init), .in_base_init(in_base_init),
    .weight_done(weight_done), .wr_done(wr_done),
    .wl_start(wl_start), .rd_active(rd_active), .w_base(w_base),
    .in_base(in_base), .tile_idx(tile_idx), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Advance one cycle, sample after the edge and keep pulse statistics
  task automatic tick();
    @(posedge clk);
    #1;
    if ((wl_start && p_wl) || (rd_active && p_rd) || (done && p_done)) consec++;
    p_wl = wl_start; p_rd = rd_active; p_done = done;
    if (wl_start)  wl_cnt++;
    if (rd_active) rd_cnt++;
    if (done)      done_cnt++;
    if (busy)      busy_cnt++;
  endtask

  task automatic clr_stats();
    wl_cnt = 0; rd_cnt = 0; done_cnt = 0; busy_cnt = 0; consec = 0;
  endtask

  task automatic clr_inputs();
    start = 1'b0; weight_done = 1'b0; wr_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; num_tiles = 8'd5;
    w_base_init = 8'h33; in_base_init = 8'h44;
    tick(); tick();
    checks++;
    if ({busy, wl_start, rd_active, done, error, tile_idx, w_base, in_base} !== 29'd0)
      begin fails++; $display("FAIL reset_state: got %h expected 0",
        {busy, wl_start, rd_active, done, error, tile_idx, w_base, in_base}); end
    reset = 1'b0; start = 1'b0;
    tick();
    checks++;
    if ({busy, wl_start, rd_active, done, error} !== 5'b00000)
      begin fails++; $display("FAIL reset_release: got %b expected 00000",
        {busy, wl_start, rd_active, done, error}); end
  endtask

  // Run a full job; gaps count cycles from a pulse to the sampling edge of its answer
  task automatic test_job(input int n, input logic [7:0] wb, input logic [7:0] ib,
                          input int wgap, input int cgap);
    logic [7:0] ewb, eib;
    int g;
    clr_stats();
    start = 1'b1; num_tiles = 8'(n); w_base_init = wb; in_base_init = ib;
    tick();
    start = 1'b0;
    num_tiles = 8'($urandom); w_base_init = 8'($urandom); in_base_init = 8'($urandom);
    for (int k = 0; k < n; k++) begin
      ewb = wb + 8'(k * W);
      eib = ib + 8'(k * W);
      checks++;
      if ({busy, wl_start, rd_active, done, error} !== 5'b11000 || tile_idx !== 8'(k) ||
          w_base !== ewb || in_base !== eib)
        begin fails++; $display("FAIL tile_load k=%0d: got flags %b idx %h wb %h ib %h expected 11000 %h %h %h",
          k, {busy, wl_start, rd_active, done, error}, tile_idx, w_base, in_base, 8'(k), ewb, eib); end
      g = (wgap < 0) ? int'($urandom_range(2, 12)) : wgap;
      for (int i = 1; i < g; i++) begin
        wr_done = 1'($urandom); start = 1'($urandom);
        weight_done = (i == 1) ? 1'($urandom) : 1'b0;
        tick();
        checks++;
        if ({busy, wl_start, rd_active, done} !== 4'b1000)
          begin fails++; $display("FAIL wait_weight k=%0d: got %b expected 1000",
            k, {busy, wl_start, rd_active, done}); end
      end
      weight_done = 1'b1; wr_done = 1'($urandom); start = 1'($urandom);
      tick();
      clr_inputs();
      checks++;
      if ({busy, wl_start, rd_active, done} !== 4'b1010 || tile_idx !== 8'(k))
        begin fails++; $display("FAIL rd_pulse k=%0d: got %b idx %h expected 1010 %h",
          k, {busy, wl_start, rd_active, done}, tile_idx, 8'(k)); end
      g = (cgap < 0) ? int'($urandom_range(2, 12)) : cgap;
      for (int i = 1; i < g; i++) begin
        weight_done = 1'($urandom); start = 1'($urandom);
        wr_done = (i == 1) ? 1'($urandom) : 1'b0;
        tick();
        checks++;
        if ({busy, wl_start, rd_active, done} !== 4'b1000)
          begin fails++; $display("FAIL wait_write k=%0d: got %b expected 1000",
            k, {busy, wl_start, rd_active, done}); end
      end
      wr_done = 1'b1; weight_done = 1'($urandom); start = 1'($urandom);
      tick();
      clr_inputs();
      if (k == n - 1) begin
        checks++;
        if ({busy, wl_start, rd_active, done, error} !== 5'b00010)
          begin fails++; $display("FAIL job_done: got %b expected 00010",
            {busy, wl_start, rd_active, done, error}); end
      end
    end
    tick();
    checks++;
    if ({busy, wl_start, rd_active, done} !== 4'b0000)
      begin fails++; $display("FAIL post_done: got %b expected 0000",
        {busy, wl_start, rd_active, done}); end
    checks++;
    if (wl_cnt !== n || rd_cnt !== n || done_cnt !== 1 || consec !== 0)
      begin fails++; $display("FAIL pulse_counts: got wl %0d rd %0d done %0d consec %0d expected %0d %0d 1 0",
        wl_cnt, rd_cnt, done_cnt, consec, n, n); end
  endtask

  task automatic test_zero_tiles();
    clr_stats();
    start = 1'b1; num_tiles = 8'd0;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, wl_start, rd_active, done, error} !== 5'b00010)
      begin fails++; $display("FAIL zero_done: got %b expected 00010",
        {busy, wl_start, rd_active, done, error}); end
    tick(); tick();
    checks++;
    if (done !== 1'b0 || wl_cnt !== 0 || rd_cnt !== 0 || busy_cnt !== 0 || done_cnt !== 1)
      begin fails++; $display("FAIL zero_after: got done %b wl %0d rd %0d busy %0d dn %0d expected 0 0 0 0 1",
        done, wl_cnt, rd_cnt, busy_cnt, done_cnt); end
  endtask

  task automatic test_timeout();
    int t;
    clr_stats();
    start = 1'b1; num_tiles = 8'd1; w_base_init = 8'h00; in_base_init = 8'h00;
    tick();
    start = 1'b0;
    t = 0;
    do begin tick(); t++; end while (!done && t < 400);
    checks++;
    if (t !== TO + 1)
      begin fails++; $display("FAIL timeout_latency: got %0d expected %0d", t, TO + 1); end
    checks++;
    if ({busy, wl_start, rd_active, done, error} !== 5'b00011 || rd_cnt !== 0)
      begin fails++; $display("FAIL timeout_flags: got %b rd %0d expected 00011 0",
        {busy, wl_start, rd_active, done, error}, rd_cnt); end
    tick(); tick();
    checks++;
    if ({done, error} !== 2'b01)
      begin fails++; $display("FAIL error_sticky: got %b expected 01", {done, error}); end
    start = 1'b1; num_tiles = 8'd0;
    tick();
    start = 1'b0;
    checks++;
    if ({done, error} !== 2'b10)
      begin fails++; $display("FAIL error_clear: got %b expected 10", {done, error}); end
  endtask

  // Done inputs land exactly on the last watchdog cycle of each wait state
  task automatic test_timeout_race();
    start = 1'b1; num_tiles = 8'd1;
    tick();
    start = 1'b0;
    repeat (TO) tick();
    weight_done = 1'b1;
    tick();
    weight_done = 1'b0;
    checks++;
    if ({busy, wl_start, rd_active, done, error} !== 5'b10100)
      begin fails++; $display("FAIL race_weight: got %b expected 10100",
        {busy, wl_start, rd_active, done, error}); end
    repeat (TO) tick();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    checks++;
    if ({busy, wl_start, rd_active, done, error} !== 5'b00010)
      begin fails++; $display("FAIL race_write: got %b expected 00010",
        {busy, wl_start, rd_active, done, error}); end
    tick();
  endtask

  task automatic test_reset_midjob();
    start = 1'b1; num_tiles = 8'd3; w_base_init = 8'h40; in_base_init = 8'h80;
    tick(); start = 1'b0;
    tick(); weight_done = 1'b1;
    tick(); weight_done = 1'b0;
    tick(); wr_done = 1'b1;
    tick(); wr_done = 1'b0;
    tick(); weight_done = 1'b1;
    tick(); weight_done = 1'b0;
    tick();
    checks++;
    if ({busy, tile_idx, w_base} !== {1'b1, 8'd1, 8'h50})
      begin fails++; $display("FAIL midjob_pos: got %h expected %h",
        {busy, tile_idx, w_base}, {1'b1, 8'd1, 8'h50}); end
    clr_stats();
    reset = 1'b1; wr_done = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({busy, wl_start, rd_active, done, error, tile_idx, w_base, in_base} !== 29'd0)
      begin fails++; $display("FAIL midjob_reset: got %h expected 0",
        {busy, wl_start, rd_active, done, error, tile_idx, w_base, in_base}); end
    repeat (3) tick();
    wr_done = 1'b0;
    checks++;
    if (done_cnt !== 0 || busy !== 1'b0 || wl_cnt !== 0)
      begin fails++; $display("FAIL midjob_quiet: got done %0d busy %b wl %0d expected 0 0 0",
        done_cnt, busy, wl_cnt); end
    test_job(3, 8'h40, 8'h80, -1, -1);
  endtask

  initial begin
    clr_inputs();
    reset = 1'b1; num_tiles = 8'd0; w_base_init = 8'd0; in_base_init = 8'd0;
    clr_stats();
    test_reset();
    test_job(1, 8'h10, 8'h20, 3, 33);
    test_job(3, 8'hF0, 8'($urandom), -1, -1);
    test_zero_tiles();
    test_timeout();
    test_timeout_race();
    test_reset_midjob();
    repeat (6) test_job(int'($urandom_range(1, 5)), 8'($urandom), 8'($urandom), -1, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
